// File: rtl/or1200_vlx_pkg.sv
// rtl/or1200_vlx_pkg.sv - shared types, SPR indices and lane-select helper for the VLX Wishbone writer
package or1200_vlx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

    localparam logic [1:0] VLX_WB_SPR_PTR  = 2'd0;
    localparam logic [1:0] VLX_WB_SPR_STAT = 2'd1;
    localparam logic [1:0] VLX_WB_SPR_CNT  = 2'd2;

    localparam int VLX_WB_ENTRY_W = 36;

    // Byte lanes carried by a flushed word holding 'lanes' bytes, packed from the MSB down
    function automatic logic [3:0] vlx_partial_sel(input logic [1:0] lanes);
        logic [3:0] sel;
        case (lanes)
            2'd1:    sel = 4'b1000;
            2'd2:    sel = 4'b1100;
            2'd3:    sel = 4'b1110;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/or1200_vlx_word_fifo.sv
// rtl/or1200_vlx_word_fifo.sv - word FIFO holding {sel, data} entries for the Wishbone writer
module or1200_vlx_word_fifo
    import or1200_vlx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push,
    input  logic [VLX_WB_ENTRY_W-1:0] push_data,
    input  logic                      pop,
    output logic [VLX_WB_ENTRY_W-1:0] head,
    output logic                      full,
    output logic                      empty,
    output logic [AW:0]               count
);

    logic [VLX_WB_ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic                      wr_en;
    logic                      rd_en;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot at the same edge, so a full FIFO may still accept a push
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/or1200_vlx_wb_writer.sv
// rtl/or1200_vlx_wb_writer.sv - packs VLX bytes into words and writes them out as a Wishbone master; OR1200_VLX_WB_BYTECNT_EN adds a byte counter on SPR 2
module or1200_vlx_wb_writer
    import or1200_vlx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        err_o,
    input  logic        spr_we_i,
    input  logic [1:0]  spr_addr_i,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_state_t                 state, state_nxt;
    logic [1:0]                lane, lane_nxt;
    logic [23:0]               hold, hold_nxt;
    logic                      flush_pending, flush_pending_nxt;
    logic                      flush_req;
    logic                      accept;
    logic                      word_push;
    logic                      part_push;
    logic                      push;
    logic                      pop;
    logic [VLX_WB_ENTRY_W-1:0] push_data;
    logic [VLX_WB_ENTRY_W-1:0] head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [31:0]               fifo_count32;
    logic [3:0]                cnt_sat;
    logic [31:0]               ptr;
    logic                      err_q;
    logic                      in_write;
    logic                      unused_spr_lsbs;

    assign byte_ready_o = !(lane == 2'd3 && fifo_full) && !flush_pending;
    assign accept       = byte_valid_i && byte_ready_o;
    assign flush_req    = flush_i || flush_pending;
    assign push         = word_push || part_push;

    // Pack the incoming byte first; a flush then sees the post-pack lane count
    always_comb begin
        lane_nxt  = lane;
        hold_nxt  = hold;
        word_push = 1'b0;
        part_push = 1'b0;
        push_data = '0;
        if (accept) begin
            case (lane)
                2'd0:    hold_nxt[23:16] = byte_i;
                2'd1:    hold_nxt[15:8]  = byte_i;
                2'd2:    hold_nxt[7:0]   = byte_i;
                default: word_push       = 1'b1;
            endcase
            lane_nxt = lane + 2'd1;
        end
        if (word_push) begin
            push_data = {4'hF, hold, byte_i};
            hold_nxt  = '0;
        end else if (flush_req && lane_nxt != 2'd0 && !fifo_full) begin
            part_push = 1'b1;
            push_data = {vlx_partial_sel(lane_nxt), hold_nxt, 8'h00};
            hold_nxt  = '0;
            lane_nxt  = 2'd0;
        end
        flush_pending_nxt = flush_req && (lane_nxt != 2'd0);
    end

    or1200_vlx_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty)
                    state_nxt = WRITE;
            end
            WRITE: begin
                if (wb_ack_i || wb_err_i) begin
                    pop = 1'b1;
                    if (fifo_count <= CW'(1) && !push)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            lane          <= 2'd0;
            hold          <= '0;
            flush_pending <= 1'b0;
            ptr           <= '0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_nxt;
            lane          <= lane_nxt;
            hold          <= hold_nxt;
            flush_pending <= flush_pending_nxt;
            if (spr_we_i && spr_addr_i == VLX_WB_SPR_PTR && !busy_o)
                ptr <= {spr_dat_i[31:2], 2'b00};
            else if (pop)
                ptr <= ptr + 32'd4;
            if (pop && wb_err_i)
                err_q <= 1'b1;
            else if (spr_we_i && spr_addr_i == VLX_WB_SPR_STAT)
                err_q <= 1'b0;
        end
    end

`ifdef OR1200_VLX_WB_BYTECNT_EN
    logic [31:0] byte_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            byte_cnt <= '0;
        else if (spr_we_i && spr_addr_i == VLX_WB_SPR_CNT)
            byte_cnt <= '0;
        else if (accept)
            byte_cnt <= byte_cnt + 32'd1;
    end
`endif

    assign fifo_count32 = 32'(fifo_count);
    assign cnt_sat      = (fifo_count32 > 32'd15) ? 4'hF : fifo_count32[3:0];

    always_comb begin
        spr_dat_o = '0;
        case (spr_addr_i)
            VLX_WB_SPR_PTR:  spr_dat_o = ptr;
            VLX_WB_SPR_STAT: spr_dat_o = {busy_o, err_q, 26'd0, cnt_sat};
`ifdef OR1200_VLX_WB_BYTECNT_EN
            VLX_WB_SPR_CNT:  spr_dat_o = byte_cnt;
`endif
            default:         spr_dat_o = '0;
        endcase
    end

    assign unused_spr_lsbs = ^spr_dat_i[1:0];

    assign busy_o   = (lane != 2'd0) || flush_pending || !fifo_empty || (state == WRITE);
    assign err_o    = err_q;
    assign in_write = (state == WRITE);
    assign wb_cyc_o = in_write;
    assign wb_stb_o = in_write;
    assign wb_we_o  = in_write;
    assign wb_adr_o = ptr;
    assign wb_sel_o = in_write ? head[35:32] : 4'h0;
    assign wb_dat_o = in_write ? head[31:0] : 32'h0;

endmodule

// File: tb/tb_or1200_vlx_wb_writer.sv
// tb/tb_or1200_vlx_wb_writer.sv - scoreboard bench for or1200_vlx_wb_writer
module tb_or1200_vlx_wb_writer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_ready_o;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        err_o;
    logic        spr_we_i = 1'b0;
    logic [1:0]  spr_addr_i = 2'd0;
    logic [31:0] spr_dat_i = 32'h0;
    logic [31:0] spr_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i, wb_err_i;
    logic        ack_en = 1'b0;
    logic        err_en = 1'b0;

    assign wb_ack_i = wb_stb_o && ack_en && !err_en;
    assign wb_err_i = wb_stb_o && err_en;

    or1200_vlx_wb_writer #(.FIFO_DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .spr_we_i     (spr_we_i),
        .spr_addr_i   (spr_addr_i),
        .spr_dat_i    (spr_dat_i),
        .spr_dat_o    (spr_dat_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_sel_o     (wb_sel_o),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    logic [31:0] last_dat = 32'h0;
    logic [3:0]  last_sel = 4'h0;
    logic [7:0]  m_b[4];
    int          m_lane = 0;
    logic [31:0] m_adr = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_push(input logic [31:0] dat, input logic [3:0] sel);
        exp_t e;
        e.adr = m_adr;
        e.dat = dat;
        e.sel = sel;
        exp_q.push_back(e);
        m_adr = m_adr + 32'd4;
    endtask

    task automatic model_accept(input logic [7:0] b);
        m_b[m_lane] = b;
        m_lane++;
        if (m_lane == 4) begin
            model_push({m_b[0], m_b[1], m_b[2], m_b[3]}, 4'hF);
            m_lane = 0;
        end
    endtask

    task automatic model_flush();
        logic [31:0] w;
        logic [3:0]  s;
        if (m_lane != 0) begin
            w = {m_b[0], (m_lane > 1) ? m_b[1] : 8'h00, (m_lane > 2) ? m_b[2] : 8'h00, 8'h00};
            s = (m_lane == 1) ? 4'b1000 : (m_lane == 2) ? 4'b1100 : 4'b1110;
            model_push(w, s);
            m_lane = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_flush);
        int n = 0;
        byte_valid_i = 1'b1;
        byte_i = b;
        while (!byte_ready_o && n < 300) begin
            tick();
            n++;
        end
        if (!byte_ready_o) begin
            check("byte_ready_timeout", 32'd0, 32'd1);
            byte_valid_i = 1'b0;
            return;
        end
        flush_i = with_flush;
        model_accept(b);
        if (with_flush)
            model_flush();
        tick();
        byte_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        model_flush();
        tick();
        flush_i = 1'b0;
    endtask

    task automatic spr_write(input logic [1:0] a, input logic [31:0] d);
        spr_we_i = 1'b1;
        spr_addr_i = a;
        spr_dat_i = d;
        tick();
        spr_we_i = 1'b0;
    endtask

    task automatic spr_read(input logic [1:0] a, output logic [31:0] d);
        spr_addr_i = a;
        #1;
        d = spr_dat_o;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        while (!wb_stb_o && n < 100) begin
            tick();
            n++;
        end
        check(tag, {31'd0, wb_stb_o}, 32'd1);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
            exp_t e;
            n_writes++;
            last_dat = wb_dat_o;
            last_sel = wb_sel_o;
            if (exp_q.size() == 0) begin
                check("unexpected_write", wb_dat_o, 32'hXXXX_XXXX);
            end else begin
                e = exp_q.pop_front();
                check("wb_adr", wb_adr_o, e.adr);
                check("wb_dat", wb_dat_o, e.dat);
                check("wb_sel", {28'd0, wb_sel_o}, {28'd0, e.sel});
                check("wb_we", {31'd0, wb_we_o}, 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          w0;
        int          bytes_done;
        logic [7:0]  t1 [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'd0, byte_ready_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();
        spr_read(2'd0, d);
        check("rst_ptr", d, 32'd0);

        // Two full words to 0x1000
        spr_write(2'd0, 32'h0000_1003);
        m_adr = 32'h0000_1000;
        spr_read(2'd0, d);
        check("ptr_load", d, 32'h0000_1000);
        ack_en = 1'b1;
        w0 = n_writes;
        foreach (t1[i]) send_byte(t1[i], 1'b0);
        wait_idle("t1");
        check("t1_writes", n_writes - w0, 32'd2);
        spr_read(2'd0, d);
        check("t1_ptr", d, 32'h0000_1008);

        // Partial word flush
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAB, 1'b0);
        check("t2_busy_lane", {31'd0, busy_o}, 32'd1);
        do_flush();
        check("t2_busy_flush", {31'd0, busy_o}, 32'd1);
        wait_idle("t2");
        check("t2_dat", last_dat, 32'hFF00_AB00);
        check("t2_sel", {28'd0, last_sel}, 32'hE);

        // Back-pressure: ack withheld for 40 cycles while 24 bytes stream in
        ack_en = 1'b0;
        bytes_done = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send_byte(8'(i * 7 + 3), 1'b0);
                    bytes_done++;
                end
            end
            begin
                logic [31:0] s;
                repeat (40) tick();
                check("bp_accepted", bytes_done, 32'd19);
                check("bp_ready", {31'd0, byte_ready_o}, 32'd0);
                spr_read(2'd1, s);
                check("bp_stat", s, 32'h8000_0004);
                spr_write(2'd0, 32'h5555_0000);
                ack_en = 1'b1;
            end
        join
        wait_idle("bp");
        spr_read(2'd0, d);
        check("bp_ptr_kept", d, m_adr);

        // Bus error on the first word, next word continues at ptr+4
        err_en = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 1'b0);
        wait_stb("err_stb");
        tick();
        err_en = 1'b0;
        check("err_set", {31'd0, err_o}, 32'd1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hD0 + i), 1'b0);
        wait_idle("err");
        spr_read(2'd1, d);
        check("err_stat", d, 32'h4000_0000);
        spr_write(2'd1, 32'h0);
        check("err_clear", {31'd0, err_o}, 32'd0);

        // Flush together with the byte that completes a word
        w0 = n_writes;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_idle("same");
        check("same_writes", n_writes - w0, 32'd1);
        check("same_sel", {28'd0, last_sel}, 32'hF);

        // Flush while the FIFO is full stays pending
        ack_en = 1'b0;
        for (int i = 0; i < 18; i++) send_byte(8'(8'h60 + i), 1'b0);
        do_flush();
        check("fp_ready", {31'd0, byte_ready_o}, 32'd0);
        spr_read(2'd1, d);
        check("fp_count", {28'd0, d[3:0]}, 32'd4);
        ack_en = 1'b1;
        wait_idle("fp");
        check("fp_sel", {28'd0, last_sel}, 32'hC);
        check("fp_dat", last_dat, 32'h7071_0000);

`ifdef OR1200_VLX_WB_BYTECNT_EN
        spr_write(2'd2, 32'h0);
        for (int i = 0; i < 7; i++) send_byte(8'(i + 1), 1'b0);
        spr_read(2'd2, d);
        check("cnt_seven", d, 32'd7);
        do_flush();
        spr_write(2'd2, 32'h0);
        spr_read(2'd2, d);
        check("cnt_clear", d, 32'd0);
        wait_idle("cnt");
`else
        spr_read(2'd2, d);
        check("cnt_absent", d, 32'd0);
`endif

        // Asynchronous reset in mid-cycle while a write is outstanding
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1'b0);
        wait_stb("ar_stb");
        #2 rst_i = 1'b1;
        #1;
        check("ar_stb_drop", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("ar_busy", {31'd0, busy_o}, 32'd0);
        exp_q.delete();
        m_lane = 0;
        m_adr = 32'h0;
        tick();
        rst_i = 1'b0;
        tick();
        spr_read(2'd0, d);
        check("ar_ptr", d, 32'd0);
        check("ar_ready", {31'd0, byte_ready_o}, 32'd1);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or1200_vlx_wb_writer.md
# or1200_vlx_wb_writer

Downstream consumer of the VLX bit-packing datapath: accepts the stream of Huffman-coded, 0xFF/0x00-stuffed bytes it emits, assembles them big-endian into 32-bit words, buffers them in a small FIFO and writes them to memory as a Wishbone classic master. Software sets the destination pointer and flushes the final partial word through SPRs. This lets the encoder loop run without per-byte store instructions.

## Interface
- FIFO_DEPTH, 4: word FIFO entries; power of two, at least 2.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- byte_valid_i  in  1  byte_i holds a byte to store
- byte_i  in  8  stuffed output byte from the VLX datapath
- byte_ready_o  out  1  byte accepted at this edge if byte_valid_i
- flush_i  in  1  one-cycle pulse: push partial word, drain FIFO
- busy_o  out  1  packer, FIFO or bus not idle
- err_o  out  1  sticky Wishbone error flag
- spr_we_i  in  1  SPR write strobe
- spr_addr_i  in  2  0 = address pointer, 1 = status, 2 = byte count
- spr_dat_i  in  32  SPR write data
- spr_dat_o  out  32  SPR read data, combinational on spr_addr_i
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls
- wb_adr_o  out  32  word address, bits [1:0] always 0
- wb_sel_o  out  4  byte lane selects
- wb_dat_o  out  32  write data
- wb_ack_i, wb_err_i  in  1 each  Wishbone termination

## Operation
- Packer: 2-bit lane counter plus 24-bit holding register. Lane 0 goes to [31:24], lane 3 to [7:0]. A byte on the 4th lane pushes {hold, byte_i} with sel 4'hF and resets lane to 0.
- byte_ready_o = !(lane==3 && fifo_full) && !flush_pending.
- Flush: if lane != 0, push the partial word with sel 1000/1100/1110 for lane 1/2/3; unused bytes are 0. Lane is then reset. If the FIFO is full, flush_pending holds until space is available. A flush with lane==0 only drains the FIFO.
- Accept and flush in the same cycle: the byte is packed first, then the flush applies to the result. If that byte completes a word, no partial push occurs.
- Bus FSM: IDLE and WRITE.
  - IDLE -> WRITE when the FIFO is non-empty. cyc, stb and we are asserted, with adr = ptr and dat/sel taken from the FIFO head.
  - In WRITE, on ack or err: pop the head and add 4 to ptr (wrap at 2^32). Stay in WRITE if another entry is present, otherwise return to IDLE.
  - err additionally sets err_o.
- SPR 0:
  - Write loads ptr = {spr_dat_i[31:2], 2'b00}; the write is ignored while busy_o.
  - Read returns ptr.
- SPR 1:
  - Read returns {busy, err, 26'b0, count}, with count in bits [3:0], saturated.
  - Any write clears err_o.
- busy_o = (lane != 0) | flush_pending | !fifo_empty | (state==WRITE).

## Timing
- Reset values:
  - FSM IDLE, ptr 0, lane 0, FIFO empty.
  - All wb_* outputs 0; busy_o 0, err_o 0, byte_ready_o 1.
- Word push at edge N sets wb_stb_o high in cycle N+1 from registered state. Outputs never depend combinationally on wb_ack_i.
- Ack in the same cycle as stb is legal. Back-to-back words keep stb high with the next word in the cycle after ack.
- A push and a pop in the same cycle leave the FIFO count unchanged and are legal when the FIFO is full.
- Asynchronous reset mid-cycle drops cyc/stb immediately and discards buffered data.

## Configuration
- OR1200_VLX_WB_BYTECNT_EN defined:
  - A 32-bit counter increments on every accepted byte.
  - SPR 2 reads the counter; a write to SPR 2 clears it.
- Undefined: there is no counter, and SPR 2 reads 0.

## Structure
- Shared package or1200_vlx_pkg:
  - wb_state_t enum {IDLE, WRITE}.
  - SPR index constants VLX_WB_SPR_PTR/STAT/CNT.
  - Partial-sel lookup function.
- Sub-module or1200_vlx_word_fifo: synchronous FIFO with 36-bit entries (32 data + 4 sel), push/pop, full/empty/count, FIFO_DEPTH.

## Test plan
- Ptr=0x1000; bytes 12,34,56,78,9A,BC,DE,F0, ack held high -> writes 0x12345678 @0x1000 and 0x9ABCDEF0 @0x1004, sel F both.
- Bytes FF,00,AB then flush -> one write 0xFF00AB00 sel 1110; busy_o falls after ack.
- wb_ack_i low for 40 cycles, 24 bytes streamed -> byte_ready_o drops after 4 full words plus 3 held bytes; no byte lost or duplicated after ack resumes.
- wb_err_i on the first write -> err_o=1, next word goes to ptr+4; SPR1 write clears err_o.
- Flush and 4th byte in the same cycle -> exactly one full-word write, no extra partial write.
- With OR1200_VLX_WB_BYTECNT_EN: 7 bytes -> SPR2 reads 7; SPR2 write then reads 0.
